// File: rtl/inv_state_array.sv
// Byte-serial 4x4 AES state buffer for the decrypt path: loads 16 bytes column-major,
// applies InvShiftRows in place, and streams the result one column per valid/ready beat.

module inv_state_row #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [1:0]            wr_col,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rot_en,
    output logic [3:0][WIDTH-1:0] row
);

    // Right rotation: new[c] = old[(c+3)%4]
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
        end else if (clr) begin
            row <= '0;
        end else if (wr_en) begin
            row[wr_col] <= wr_data;
        end else if (rot_en) begin
            row <= {row[2], row[1], row[0], row[3]};
        end
    end

endmodule

module inv_state_array #(
    parameter int WIDTH = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_clr,
    input  logic               i_in_valid,
    output logic               o_in_ready,
    input  logic [WIDTH-1:0]   i_in_data,
    output logic               o_col_valid,
    input  logic               i_col_ready,
    output logic [4*WIDTH-1:0] o_col_data,
    output logic [1:0]         o_col_idx,
    output logic               o_busy
);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_UNLOAD = 2'd2
    } state_t;

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [1:0] k, k_n;
    logic [1:0] idx, idx_n;

    logic [3:0][3:0][WIDTH-1:0] s;
    logic load_fire;

    // A clear in the same cycle suppresses the store
    assign load_fire = (state == ST_LOAD) && i_in_valid && !i_clr;

    for (genvar r = 0; r < 4; r++) begin : g_row
        inv_state_row #(.WIDTH(WIDTH)) u_row (
            .clk     (i_clk),
            .rst_n   (i_rst_n),
            .clr     (i_clr),
            .wr_en   (load_fire && (cnt[1:0] == 2'(r))),
            .wr_col  (cnt[3:2]),
            .wr_data (i_in_data),
            .rot_en  ((state == ST_SHIFT) && (2'(r) >= k)),
            .row     (s[r])
        );
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_LOAD;
            cnt   <= '0;
            k     <= '0;
            idx   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            k     <= k_n;
            idx   <= idx_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        k_n     = k;
        idx_n   = idx;
        if (i_clr) begin
            state_n = ST_LOAD;
            cnt_n   = '0;
            k_n     = '0;
            idx_n   = '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (i_in_valid) begin
                        cnt_n = cnt + 4'd1;
                        if (cnt == 4'd15) begin
                            state_n = ST_SHIFT;
                            k_n     = 2'd1;
                        end
                    end
                end
                ST_SHIFT: begin
                    k_n = k + 2'd1;
                    if (k == 2'd3) state_n = ST_UNLOAD;
                end
                ST_UNLOAD: begin
                    if (i_col_ready) begin
                        idx_n = idx + 2'd1;
                        if (idx == 2'd3) state_n = ST_LOAD;
                    end
                end
                default: begin
                    state_n = ST_LOAD;
                    cnt_n   = '0;
                    k_n     = '0;
                    idx_n   = '0;
                end
            endcase
        end
    end

    assign o_in_ready  = (state == ST_LOAD);
    assign o_col_valid = (state == ST_UNLOAD);
    assign o_busy      = (state == ST_SHIFT) || (state == ST_UNLOAD);
    assign o_col_idx   = idx;

    always_comb begin
        o_col_data = '0;
        if (state == ST_UNLOAD)
            o_col_data = {s[0][idx], s[1][idx], s[2][idx], s[3][idx]};
    end

endmodule

// File: tb/tb_inv_state_array.sv
// Directed bench for inv_state_array: load/shift/unload, bubbles, backpressure,
// async reset, synchronous clear and back-to-back blocks.

module tb_inv_state_array;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_clr = 1'b0;
    logic        i_in_valid = 1'b0;
    logic        o_in_ready;
    logic [7:0]  i_in_data = 8'h00;
    logic        o_col_valid;
    logic        i_col_ready = 1'b0;
    logic [31:0] o_col_data;
    logic [1:0]  o_col_idx;
    logic        o_busy;

    int passed = 0;
    int total  = 0;
    int fails  = 0;
    int hs_cnt = 0;

    inv_state_array #(.WIDTH(8)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_clr       (i_clr),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_in_data   (i_in_data),
        .o_col_valid (o_col_valid),
        .i_col_ready (i_col_ready),
        .o_col_data  (o_col_data),
        .o_col_idx   (o_col_idx),
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk)
        if (i_rst_n && !i_clr && i_in_valid && o_in_ready) hs_cnt++;

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_col(input int pat, input int c);
        logic [31:0] t [4];
        t[0] = 32'h000D0A07;
        t[1] = 32'h04010E0B;
        t[2] = 32'h0805020F;
        t[3] = 32'h0C090603;
        return (pat == 1) ? 32'hA5A5A5A5 : t[c];
    endfunction

    // pat 0: bytes 0x00..0x0F, pat 1: all 0xA5; gap inserts a bubble between bytes
    task automatic load_block(input int pat, input bit gap, input int n);
        for (int b = 0; b < n; b++) begin
            i_in_valid = 1'b1;
            i_in_data  = (pat == 1) ? 8'hA5 : 8'(b);
            tick();
            if (gap && b != n - 1) begin
                i_in_valid = 1'b0;
                i_in_data  = 8'hEE;
                tick();
            end
        end
        i_in_valid = 1'b0;
    endtask

    // Called right after the last byte's edge; expects valid exactly 3 edges later
    task automatic wait_shift(input string tag);
        chk({tag, "_busy"}, {31'b0, o_busy}, 32'd1);
        chk({tag, "_rdy0"}, {31'b0, o_in_ready}, 32'd0);
        tick();
        tick();
        chk({tag, "_v_early"}, {31'b0, o_col_valid}, 32'd0);
        tick();
        chk({tag, "_v_on"}, {31'b0, o_col_valid}, 32'd1);
    endtask

    task automatic unload(input string tag, input int pat, input int first);
        for (int c = first; c < 4; c++) begin
            chk($sformatf("%s_col%0d", tag, c), o_col_data, exp_col(pat, c));
            chk($sformatf("%s_idx%0d", tag, c), {30'b0, o_col_idx}, 32'(c));
            i_col_ready = 1'b1;
            tick();
        end
        i_col_ready = 1'b0;
        chk({tag, "_rdy_back"}, {31'b0, o_in_ready}, 32'd1);
        chk({tag, "_v_off"}, {31'b0, o_col_valid}, 32'd0);
        chk({tag, "_data0"}, o_col_data, 32'd0);
    endtask

    initial begin
        int hs0;
        // reset state
        tick();
        tick();
        chk("rst_rdy", {31'b0, o_in_ready}, 32'd1);
        chk("rst_valid", {31'b0, o_col_valid}, 32'd0);
        chk("rst_data", o_col_data, 32'd0);
        chk("rst_idx", {30'b0, o_col_idx}, 32'd0);
        chk("rst_busy", {31'b0, o_busy}, 32'd0);
        i_rst_n = 1'b1;
        tick();

        // 1: continuous load
        load_block(0, 1'b0, 16);
        wait_shift("t1");
        unload("t1", 0, 0);

        // 2: bubbles every other cycle
        hs0 = hs_cnt;
        load_block(0, 1'b1, 16);
        chk("t2_hs", 32'(hs_cnt - hs0), 32'd16);
        wait_shift("t2");
        unload("t2", 0, 0);

        // 3: backpressure on column 1
        load_block(0, 1'b0, 16);
        wait_shift("t3");
        i_col_ready = 1'b1;
        tick();
        i_col_ready = 1'b0;
        i_in_valid  = 1'b1;
        for (int h = 0; h < 5; h++) begin
            tick();
            chk($sformatf("t3_hold_d%0d", h), o_col_data, 32'h04010E0B);
            chk($sformatf("t3_hold_v%0d", h), {31'b0, o_col_valid}, 32'd1);
            chk($sformatf("t3_hold_r%0d", h), {31'b0, o_in_ready}, 32'd0);
        end
        i_in_valid = 1'b0;
        unload("t3", 0, 1);

        // 4: async reset mid-load and mid-unload
        load_block(0, 1'b0, 9);
        i_rst_n = 1'b0;
        #1;
        chk("t4_rst_rdy", {31'b0, o_in_ready}, 32'd1);
        chk("t4_rst_busy", {31'b0, o_busy}, 32'd0);
        tick();
        i_rst_n = 1'b1;
        load_block(0, 1'b0, 16);
        wait_shift("t4");
        i_rst_n = 1'b0;
        #1;
        chk("t4_rst_v", {31'b0, o_col_valid}, 32'd0);
        chk("t4_rst_d", o_col_data, 32'd0);
        tick();
        i_rst_n = 1'b1;
        load_block(0, 1'b0, 16);
        wait_shift("t4b");
        unload("t4", 0, 0);

        // 5: clear during unload at idx 2 with ready high
        load_block(0, 1'b0, 16);
        wait_shift("t5");
        i_col_ready = 1'b1;
        tick();
        tick();
        chk("t5_idx2", {30'b0, o_col_idx}, 32'd2);
        i_clr = 1'b1;
        tick();
        i_clr = 1'b0;
        i_col_ready = 1'b0;
        chk("t5_rdy", {31'b0, o_in_ready}, 32'd1);
        chk("t5_v", {31'b0, o_col_valid}, 32'd0);
        chk("t5_idx", {30'b0, o_col_idx}, 32'd0);
        chk("t5_busy", {31'b0, o_busy}, 32'd0);
        chk("t5_s_zero", {31'b0, |dut.s}, 32'd0);
        // clear mid-load with a concurrent byte: counter restarts, byte dropped
        load_block(0, 1'b0, 5);
        i_clr = 1'b1;
        i_in_valid = 1'b1;
        i_in_data = 8'hFF;
        tick();
        i_clr = 1'b0;
        i_in_valid = 1'b0;
        load_block(0, 1'b0, 16);
        wait_shift("t5b");
        unload("t5b", 0, 0);

        // 6: back-to-back blocks
        load_block(0, 1'b0, 16);
        wait_shift("t6a");
        unload("t6a", 0, 0);
        load_block(1, 1'b0, 16);
        wait_shift("t6b");
        unload("t6b", 1, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
